// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, a one-entry buffer holds an LLU result.
// Define RF_ARB_STARVE_EN to add the starvation counter and the one-cycle STEAL pipeline freeze.
module rf_wr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_wdata,
    input  logic        llu_valid,
    input  logic [4:0]  llu_rd_addr,
    input  logic [31:0] llu_wdata,
    output logic        llu_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  dbg_state
);

    // Handshake: an LLU result transfers on a rising edge where llu_valid && llu_ready;
    // the LLU keeps llu_rd_addr/llu_wdata stable until that edge.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
`ifdef RF_ARB_STARVE_EN
    localparam logic [1:0] STEAL = 2'd2;
    localparam logic [3:0] CNT_LAST = 4'(STARVE_LIMIT - 1);
`endif

    logic [1:0]  state, state_n;
    logic [4:0]  hold_rd;
    logic [31:0] hold_data;
    logic        hold_valid;
    logic        wb_act;
    logic        accept;
    logic        grant_wb, grant_hold;
`ifdef RF_ARB_STARVE_EN
    logic [3:0]  cnt, cnt_n;
`endif

    // The buffer is occupied exactly when the FSM is outside IDLE.
    assign hold_valid = (state != IDLE);
    assign llu_ready  = !hold_valid && !rst_;
    assign wb_act     = wb_reg_write && (wb_rd_addr != 5'd0);
    assign accept     = llu_valid && llu_ready;
    assign dbg_state  = state;

    always_comb begin
        state_n    = state;
        grant_wb   = 1'b0;
        grant_hold = 1'b0;
`ifdef RF_ARB_STARVE_EN
        cnt_n      = cnt;
`endif
        case (state)
            IDLE: begin
                grant_wb = wb_act;
                if (accept && (llu_rd_addr != 5'd0)) begin
                    state_n = PEND;
`ifdef RF_ARB_STARVE_EN
                    cnt_n   = 4'd0;
`endif
                end
            end
            PEND: begin
                if (wb_act) begin
                    grant_wb = 1'b1;
                    // A younger WB write to the same register supersedes the held result.
                    if (wb_rd_addr == hold_rd) begin
                        state_n = IDLE;
                    end else begin
`ifdef RF_ARB_STARVE_EN
                        cnt_n = cnt + 4'd1;
                        if (cnt == CNT_LAST) state_n = STEAL;
`endif
                    end
                end else begin
                    grant_hold = 1'b1;
                    state_n    = IDLE;
                end
            end
`ifdef RF_ARB_STARVE_EN
            STEAL: begin
                grant_hold = 1'b1;
                state_n    = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state     <= IDLE;
            hold_rd   <= 5'd0;
            hold_data <= 32'd0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                hold_rd   <= llu_rd_addr;
                hold_data <= llu_wdata;
            end
            rf_we <= grant_wb || grant_hold;
            if (grant_wb) begin
                rf_waddr <= wb_rd_addr;
                rf_wdata <= wb_wdata;
            end else if (grant_hold) begin
                rf_waddr <= hold_rd;
                rf_wdata <= hold_data;
            end
        end
    end

`ifdef RF_ARB_STARVE_EN
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            cnt        <= 4'd0;
            pipe_stall <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            pipe_stall <= (state_n == STEAL);
        end
    end
`else
    assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter; expectations follow the enabled configuration.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        rst_;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_wdata;
    logic        llu_valid;
    logic [4:0]  llu_rd_addr;
    logic [31:0] llu_wdata;
    logic        llu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    rf_wr_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .wb_reg_write (wb_reg_write),
        .wb_rd_addr   (wb_rd_addr),
        .wb_wdata     (wb_wdata),
        .llu_valid    (llu_valid),
        .llu_rd_addr  (llu_rd_addr),
        .llu_wdata    (llu_wdata),
        .llu_ready    (llu_ready),
        .pipe_stall   (pipe_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .dbg_state    (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_reg_write = en;
        wb_rd_addr   = rd;
        wb_wdata     = data;
    endtask

    task automatic drive_llu(input logic v, input logic [4:0] rd, input logic [31:0] data);
        llu_valid   = v;
        llu_rd_addr = rd;
        llu_wdata   = data;
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_llu(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b want=0", rf_we); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_rf_waddr got=%0d want=0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata got=%h want=0", rf_wdata); end
        total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_pipe_stall got=%b want=0", pipe_stall); end
        total++; if (llu_ready !== 1'b0) begin bad++; $display("FAIL reset_llu_ready got=%b want=0", llu_ready); end
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        total++; if (llu_ready !== 1'b1) begin bad++; $display("FAIL release_llu_ready got=%b want=1", llu_ready); end
    endtask

    task automatic test_wb_only();
        drive_wb(1'b1, 5'd10, 32'h12345678);
        tick();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL wb_rf_we got=%b want=1", rf_we); end
        total++; if (rf_waddr !== 5'd10) begin bad++; $display("FAIL wb_rf_waddr got=%0d want=10", rf_waddr); end
        total++; if (rf_wdata !== 32'h12345678) begin bad++; $display("FAIL wb_rf_wdata got=%h want=12345678", rf_wdata); end
        drive_wb(1'b1, 5'd0, 32'hFFFF0000);
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL wb_x0_rf_we got=%b want=0", rf_we); end
        drive_wb(1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_llu_idle();
        drive_llu(1'b1, 5'd7, 32'hDEADBEEF);
        #1;
        total++; if (llu_ready !== 1'b1) begin bad++; $display("FAIL llu_ready_pre got=%b want=1", llu_ready); end
        tick();
        drive_llu(1'b0, 5'd0, 32'd0);
        total++; if (llu_ready !== 1'b0) begin bad++; $display("FAIL llu_ready_held got=%b want=0", llu_ready); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL llu_early_rf_we got=%b want=0", rf_we); end
        tick();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL llu_rf_we got=%b want=1", rf_we); end
        total++; if (rf_waddr !== 5'd7) begin bad++; $display("FAIL llu_rf_waddr got=%0d want=7", rf_waddr); end
        total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL llu_rf_wdata got=%h want=deadbeef", rf_wdata); end
        total++; if (llu_ready !== 1'b1) begin bad++; $display("FAIL llu_ready_back got=%b want=1", llu_ready); end
        tick();
    endtask

    task automatic test_llu_x0();
        drive_llu(1'b1, 5'd0, 32'h55555555);
        tick();
        drive_llu(1'b0, 5'd0, 32'd0);
        total++; if (llu_ready !== 1'b1) begin bad++; $display("FAIL llu_x0_ready got=%b want=1", llu_ready); end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL llu_x0_rf_we got=%b want=0", rf_we); end
    endtask

    task automatic test_contention();
        logic [4:0] seq [4];
        seq[0] = 5'd3; seq[1] = 5'd4; seq[2] = 5'd6; seq[3] = 5'd8;
        drive_llu(1'b1, 5'd5, 32'hCAFE0005);
        tick();
        drive_llu(1'b0, 5'd0, 32'd0);
`ifdef RF_ARB_STARVE_EN
        // four lost arbitrations (cnt 0..3) then one STEAL cycle
        for (int i = 0; i < 4; i++) begin
            drive_wb(1'b1, seq[i], {27'd0, seq[i]});
            tick();
            total++; if (rf_waddr !== seq[i] || rf_we !== 1'b1) begin bad++; $display("FAIL cont_wb%0d got=%0d/%b want=%0d/1", i, rf_waddr, rf_we, seq[i]); end
            total++; if (pipe_stall !== (i == 3)) begin bad++; $display("FAIL cont_stall%0d got=%b want=%b", i, pipe_stall, (i == 3)); end
        end
        // WB stage is frozen: rd=11 is presented through the stall and again after
        drive_wb(1'b1, 5'd11, 32'h0000000B);
        tick();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hCAFE0005) begin bad++; $display("FAIL steal_write got=%b/%0d/%h want=1/5/cafe0005", rf_we, rf_waddr, rf_wdata); end
        total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL steal_single got=%b want=0", pipe_stall); end
        total++; if (llu_ready !== 1'b1) begin bad++; $display("FAIL steal_ready got=%b want=1", llu_ready); end
        tick();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11) begin bad++; $display("FAIL steal_replay got=%b/%0d want=1/11", rf_we, rf_waddr); end
        drive_wb(1'b0, 5'd0, 32'd0);
        tick();
`else
        for (int i = 0; i < 10; i++) begin
            drive_wb(1'b1, 5'(10 + i), 32'(10 + i));
            tick();
            total++; if (rf_waddr !== 5'(10 + i) || rf_we !== 1'b1) begin bad++; $display("FAIL cont_wb%0d got=%0d/%b want=%0d/1", i, rf_waddr, rf_we, 10 + i); end
            total++; if (pipe_stall !== 1'b0 || llu_ready !== 1'b0) begin bad++; $display("FAIL cont_hold%0d stall=%b ready=%b want=0/0", i, pipe_stall, llu_ready); end
        end
        drive_wb(1'b0, 5'd0, 32'd0);
        tick();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hCAFE0005) begin bad++; $display("FAIL cont_llu got=%b/%0d/%h want=1/5/cafe0005", rf_we, rf_waddr, rf_wdata); end
        total++; if (llu_ready !== 1'b1) begin bad++; $display("FAIL cont_ready got=%b want=1", llu_ready); end
        tick();
`endif
    endtask

    task automatic test_waw();
        drive_llu(1'b1, 5'd9, 32'h1);
        tick();
        drive_llu(1'b0, 5'd0, 32'd0);
        drive_wb(1'b1, 5'd9, 32'h2);
        tick();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h2) begin bad++; $display("FAIL waw_wb got=%b/%0d/%h want=1/9/2", rf_we, rf_waddr, rf_wdata); end
        total++; if (llu_ready !== 1'b1) begin bad++; $display("FAIL waw_ready got=%b want=1", llu_ready); end
        drive_wb(1'b0, 5'd0, 32'd0);
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL waw_dropped got=%b want=0", rf_we); end
    endtask

    task automatic test_async_reset();
        drive_llu(1'b1, 5'd12, 32'hA5A5A5A5);
        drive_wb(1'b1, 5'd13, 32'h13);
        tick();
        drive_llu(1'b0, 5'd0, 32'd0);
        drive_wb(1'b0, 5'd0, 32'd0);
        #2;
        rst_ = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin bad++; $display("FAIL async_rst_rf got=%b/%0d want=0/0", rf_we, rf_waddr); end
        total++; if (llu_ready !== 1'b0) begin bad++; $display("FAIL async_rst_ready got=%b want=0", llu_ready); end
        @(negedge clk);
        rst_ = 1'b0;
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL async_rst_lost got=%b want=0", rf_we); end
        total++; if (llu_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready_after got=%b want=1", llu_ready); end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_llu_idle();
        test_llu_x0();
        test_contention();
        test_waw();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
